// File: rtl/store_queue_pkg.sv
// store_queue_pkg: definitions shared by the store queue and the memory stage.
//   - access size encodings (SIZE_8 / SIZE_16 / SIZE_32)
//   - default datapath width SQ_XLEN and data-memory lane count
//   - store queue entry layout: word-aligned addr, lane-aligned data, byte enables
package store_queue_pkg;

  localparam int SQ_XLEN   = 32;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SIZE_8    = 2'd0,
    SIZE_16   = 2'd1,
    SIZE_32   = 2'd2,
    SIZE_RSVD = 2'd3
  } st_size_e;

  typedef struct packed {
    logic [SQ_XLEN-1:0]   addr;  // word-aligned byte address
    logic [SQ_XLEN-1:0]   data;  // lane-aligned write data
    logic [NUM_LANES-1:0] be;    // byte enables, bit i = lane i
  } sq_entry_t;

endpackage

// File: rtl/store_align.sv
// store_align: combinational lane alignment for a store.
// Ports:
//   addr_lo  in  [1:0]   low bits of the store byte address
//   data     in  [XLEN]  right-justified store data
//   size     in  [1:0]   access size (SIZE_8 / SIZE_16 / SIZE_32; 3 is illegal)
//   wdata    out [XLEN]  data replicated across all lanes
//   be       out [4]     byte enables for the addressed lanes
//   misalign out         access is not naturally aligned, or size is illegal
import store_queue_pkg::*;

module store_align #(
  parameter int XLEN = SQ_XLEN
) (
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic            misalign
);

  always_comb begin
    wdata    = '0;
    be       = '0;
    misalign = 1'b0;
    case (size)
      SIZE_8: begin
        be    = 4'b0001 << addr_lo;
        wdata = XLEN'({4{data[7:0]}});
      end
      SIZE_16: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = XLEN'({2{data[15:0]}});
        misalign = addr_lo[0];
      end
      SIZE_32: begin
        be       = 4'b1111;
        wdata    = data;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the MEM stage and data memory.
// Optional feature macro: STORE_QUEUE_FWD_EN (store-to-load forwarding of
// full-word entries; adds ld_fwd_valid / ld_fwd_data).
//
// Handshakes:
//   store side : a store is taken on a cycle with st_valid && st_ready;
//                st_ready = !full and does not look at mem_ack.
//   memory side: mem_req = !empty, head fields held until the cycle with
//                mem_req && mem_ack, which pops the head.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   st_valid/st_ready   store handshake
//   st_addr/st_data     byte address and right-justified data
//   st_size             SIZE_8 / SIZE_16 / SIZE_32
//   mem_req/mem_ack     head write handshake
//   mem_addr/mem_wdata  head write (word address, lane-aligned data)
//   mem_be              head byte enables
//   ld_check/ld_addr    load probe; ld_stall when it hits a queued word
//   ld_fwd_valid/data   (STORE_QUEUE_FWD_EN only) forwarded full word
//   misalign            one-cycle pulse after a dropped misaligned store
//   empty, count        occupancy
import store_queue_pkg::*;

module store_queue #(
  parameter int XLEN  = SQ_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [XLEN-1:0]        st_data,
  input  logic [1:0]             st_size,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_ack,
  input  logic                   ld_check,
  input  logic [XLEN-1:0]        ld_addr,
  output logic                   ld_stall,
`ifdef STORE_QUEUE_FWD_EN
  output logic                   ld_fwd_valid,
  output logic [XLEN-1:0]        ld_fwd_data,
`endif
  output logic                   misalign,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  sq_entry_t       entries [DEPTH];

  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_be;
  logic            al_mis;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  sq_entry_t       head;

  store_align #(.XLEN(XLEN)) u_align (
    .addr_lo  (st_addr[1:0]),
    .data     (st_data),
    .size     (st_size),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_mis)
  );

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  // A misaligned store is consumed (handshake completes) but never queued.
  assign push     = accept && !al_mis;
  assign pop      = mem_req && mem_ack;

  assign head      = entries[rd_ptr];
  assign mem_req   = !empty;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.data;
  assign mem_be    = head.be;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= accept && al_mis;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      entries[wr_ptr] <= '{addr: {st_addr[XLEN-1:2], 2'b00},
                           data: al_wdata,
                           be:   al_be};
    end
  end

  // Scan live entries oldest to youngest, so the last hit is the youngest.
  logic            any_match;
  logic [PW-1:0]   idx;
`ifdef STORE_QUEUE_FWD_EN
  logic            fwd_full;
  logic [XLEN-1:0] fwd_data;
`endif

  always_comb begin
    any_match = 1'b0;
    idx       = '0;
`ifdef STORE_QUEUE_FWD_EN
    fwd_full  = 1'b0;
    fwd_data  = '0;
`endif
    for (int age = 0; age < DEPTH; age++) begin
      idx = rd_ptr + PW'(age);
      if (((PW+1)'(age) < count) &&
          (entries[idx].addr[XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        any_match = 1'b1;
`ifdef STORE_QUEUE_FWD_EN
        fwd_full  = (entries[idx].be == 4'b1111);
        fwd_data  = entries[idx].data;
`endif
      end
    end
  end

`ifdef STORE_QUEUE_FWD_EN
  assign ld_fwd_valid = ld_check && any_match && fwd_full;
  assign ld_fwd_data  = fwd_data;
  assign ld_stall     = ld_check && any_match && !fwd_full;
`else
  assign ld_stall     = ld_check && any_match;
`endif

  // Loads are compared at word granularity.
  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed bench for store_queue (default XLEN=32, DEPTH=4).
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            st_valid;
  logic            st_ready;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_data;
  logic [1:0]      st_size;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic            ld_check;
  logic [XLEN-1:0] ld_addr;
  logic            ld_stall;
`ifdef STORE_QUEUE_FWD_EN
  logic            ld_fwd_valid;
  logic [XLEN-1:0] ld_fwd_data;
`endif
  logic            misalign;
  logic            empty;
  logic [2:0]      count;

  store_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .ld_check     (ld_check),
    .ld_addr      (ld_addr),
    .ld_stall     (ld_stall),
`ifdef STORE_QUEUE_FWD_EN
    .ld_fwd_valid (ld_fwd_valid),
    .ld_fwd_data  (ld_fwd_data),
`endif
    .misalign     (misalign),
    .empty        (empty),
    .count        (count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic ack_one();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] exp_addr;
    int sent;
    int cyc;
    bit acc;
    bit pp;

    vecs[0] = '{2'd0, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 1'b0};
    vecs[1] = '{2'd0, 32'h0000_0200, 32'h1234_56CD, 4'b0001, 32'hCDCD_CDCD, 1'b0};
    vecs[2] = '{2'd0, 32'h0000_0001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 1'b0};
    vecs[3] = '{2'd1, 32'h0000_0302, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0};
    vecs[4] = '{2'd1, 32'h0000_0300, 32'hFFFF_1234, 4'b0011, 32'h1234_1234, 1'b0};
    vecs[5] = '{2'd1, 32'h0000_0101, 32'h0000_1111, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[6] = '{2'd2, 32'h0000_0040, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b0};
    vecs[7] = '{2'd2, 32'h0000_0042, 32'hDEAD_BEEF, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[8] = '{2'd3, 32'h0000_0000, 32'h0000_0001, 4'b0000, 32'h0000_0000, 1'b1};

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_ack = 1'b0; ld_check = 1'b0; ld_addr = '0;
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_st_ready", 32'(st_ready), 1);
    rst = 1'b0;
    tick();

    // ack while empty is ignored
    ack_one();
    check("idle_ack_count", 32'(count), 0);
    check("idle_ack_empty", 32'(empty), 1);

    // byte store held for three cycles without ack
    push_one(2'd0, 32'h0000_0103, 32'h0000_00AB);
    for (int k = 0; k < 3; k++) begin
      check("hold_mem_req", 32'(mem_req), 1);
      check("hold_mem_addr", mem_addr, 32'h0000_0100);
      check("hold_mem_be", 32'(mem_be), 32'h8);
      check("hold_mem_wdata", mem_wdata, 32'hABAB_ABAB);
      tick();
    end
    ack_one();
    check("hold_drain_empty", 32'(empty), 1);

    // table of single stores
    for (int i = 0; i < 9; i++) begin
      check("vec_st_ready", 32'(st_ready), 1);
      push_one(vecs[i].size, vecs[i].addr, vecs[i].data);
      check("vec_misalign", 32'(misalign), 32'(vecs[i].mis));
      check("vec_count", 32'(count), vecs[i].mis ? 0 : 1);
      check("vec_mem_req", 32'(mem_req), vecs[i].mis ? 0 : 1);
      if (!vecs[i].mis) begin
        exp_addr = vecs[i].addr & 32'hFFFF_FFFC;
        check("vec_mem_addr", mem_addr, exp_addr);
        check("vec_mem_be", 32'(mem_be), 32'(vecs[i].be));
        check("vec_mem_wdata", mem_wdata, vecs[i].wdata);
        ack_one();
        check("vec_pop_count", 32'(count), 0);
      end else begin
        tick();
        check("vec_mis_pulse_end", 32'(misalign), 0);
        check("vec_mis_count", 32'(count), 0);
      end
    end

    // fill, back-pressure, ack while full
    exp_q.delete();
    st_size = 2'd2;
    for (int k = 0; k < 4; k++) begin
      st_addr  = 32'h500 + 32'(4 * k);
      st_data  = 32'hA0 + 32'(k);
      st_valid = 1'b1;
      exp_q.push_back(st_data);
      tick();
    end
    st_addr = 32'h510;
    st_data = 32'hA4;
    check("full_st_ready", 32'(st_ready), 0);
    check("full_count", 32'(count), 4);
    tick();
    check("full_held_count", 32'(count), 4);
    check("full_head", mem_wdata, exp_q[0]);
    mem_ack = 1'b1;
    check("full_ack_st_ready", 32'(st_ready), 0);
    tick();
    void'(exp_q.pop_front());
    mem_ack = 1'b0;
    check("full_ack_count", 32'(count), 3);
    check("full_ack_head", mem_wdata, exp_q[0]);
    check("full_ack_ready", 32'(st_ready), 1);
    tick();
    exp_q.push_back(32'hA4);
    st_valid = 1'b0;
    check("full_refill_count", 32'(count), 4);
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      check("full_drain_data", mem_wdata, exp_q.pop_front());
      ack_one();
    end
    check("full_drain_empty", 32'(empty), 1);

    // simultaneous enqueue and pop
    push_one(2'd2, 32'h700, 32'h0000_0701);
    st_size = 2'd2; st_addr = 32'h704; st_data = 32'h0000_0702;
    st_valid = 1'b1; mem_ack = 1'b1;
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    check("pushpop_count", 32'(count), 1);
    check("pushpop_head", mem_wdata, 32'h0000_0702);
    ack_one();

    // ten stores with random ack across pointer wrap
    exp_q.delete();
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || exp_q.size() != 0) && cyc < 400) begin
      st_valid = (sent < 10) && ($urandom_range(0, 1) == 1);
      st_size  = 2'd2;
      st_addr  = 32'h600 + 32'(4 * sent);
      st_data  = 32'hC0DE_0000 + 32'(sent);
      mem_ack  = ($urandom_range(0, 1) == 1);
      acc = st_valid && (exp_q.size() < DEPTH);
      pp  = mem_ack && (exp_q.size() > 0);
      check("rand_st_ready", 32'(st_ready), (exp_q.size() < DEPTH) ? 1 : 0);
      if (pp) begin
        check("rand_order_data", mem_wdata, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(st_data);
        sent++;
      end
      tick();
      check("rand_count", 32'(count), 32'(exp_q.size()));
      cyc++;
    end
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL rand_timeout actual=%0d required=%0d", sent, 10);
    end

    // load probe
    push_one(2'd2, 32'h40, 32'h1234_5678);
    ld_check = 1'b1;
    ld_addr  = 32'h42;
    #1;
`ifdef STORE_QUEUE_FWD_EN
    check("probe_fwd_valid", 32'(ld_fwd_valid), 1);
    check("probe_fwd_data", ld_fwd_data, 32'h1234_5678);
    check("probe_stall", 32'(ld_stall), 0);
`else
    check("probe_stall", 32'(ld_stall), 1);
`endif
    ld_addr = 32'h44;
    #1;
    check("probe_miss", 32'(ld_stall), 0);
    ld_check = 1'b0;
    ld_addr  = 32'h40;
    #1;
    check("probe_off", 32'(ld_stall), 0);
    push_one(2'd0, 32'h41, 32'h11);
    ld_check = 1'b1;
    #1;
    check("probe_partial_stall", 32'(ld_stall), 1);
`ifdef STORE_QUEUE_FWD_EN
    check("probe_partial_fwd", 32'(ld_fwd_valid), 0);
`endif
    mem_ack = 1'b1;
    #1;
    check("probe_ack_stall", 32'(ld_stall), 1);
    tick();
    mem_ack = 1'b0;
    check("probe_after_pop_stall", 32'(ld_stall), 1);
    ack_one();
    check("probe_empty_stall", 32'(ld_stall), 0);
    ld_check = 1'b0;

    // reset mid-handshake
    st_size = 2'd2;
    for (int k = 0; k < 3; k++) begin
      st_addr  = 32'h800 + 32'(4 * k);
      st_data  = 32'hE0 + 32'(k);
      st_valid = 1'b1;
      tick();
    end
    check("prerst_count", 32'(count), 3);
    check("prerst_mem_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    rst     = 1'b1;
    tick();
    check("midrst_count", 32'(count), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_mem_req", 32'(mem_req), 0);
    check("midrst_misalign", 32'(misalign), 0);
    rst = 1'b0; mem_ack = 1'b0; st_valid = 1'b0;
    tick();
    check("postrst_count", 32'(count), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
